// File: rtl/psum_writeback.sv
// Partial-sum writeback: buffers per-row psums from the PE columns and serialises
// them onto the global-buffer write port. Define PSUM_WRITEBACK_RELU_EN to clamp negative words to zero.
module psum_writeback #(
  parameter int numPeX     = 3,
  parameter int macResSize = 20,
  parameter int addrSize   = 16,
  parameter int fifoDepth  = 4
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic [numPeX*macResSize-1:0]   psum_data_i,
  input  logic [addrSize-1:0]            psum_addr_i,
  input  logic [numPeX-1:0]              psum_valid_i,
  input  logic                           cfg_enable_i,
  input  logic [addrSize-1:0]            cfg_base_addr_i,
  input  logic                           pass_done_i,
  output logic [macResSize-1:0]          wr_data_o,
  output logic [addrSize-1:0]            wr_addr_o,
  output logic                           wr_valid_o,
  input  logic                           wr_ready_i,
  output logic [$clog2(fifoDepth):0]     fifo_count_o,
  output logic                           flag_overflow_o,
  output logic                           flag_done_o
);

  localparam int ptrW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int cntW = $clog2(fifoDepth) + 1;
  localparam int colW = (numPeX > 1) ? $clog2(numPeX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_RETIRE} state_t;

  logic [numPeX*macResSize-1:0] dataMem [fifoDepth];
  logic [addrSize-1:0]          addrMem [fifoDepth];
  logic [numPeX-1:0]            maskMem [fifoDepth];

  state_t                  state_q;
  logic [ptrW-1:0]         wrPtr_q, rdPtr_q, headIdx;
  logic [cntW-1:0]         count_q, count_d;
  logic [numPeX-1:0]       remMask_q, selMask, selMaskNext;
  logic [colW-1:0]         selCol;
  logic                    wrValid_q, overflow_q, done_q, pending_q, pending_d;
  logic [macResSize-1:0]   wrData_q, rawWord, outWord;
  logic [addrSize-1:0]     wrAddr_q, selAddr;
  logic                    push, pop, full, pushOk, handshake, doneFire;

  assign push      = cfg_enable_i && (|psum_valid_i);
  assign pop       = (state_q == S_RETIRE);
  assign full      = (count_q == cntW'(fifoDepth));
  assign pushOk    = push && (!full || pop);
  assign handshake = wrValid_q && wr_ready_i;
  assign doneFire  = pending_q && (count_q == '0) && (state_q == S_IDLE);
  assign count_d   = count_q + cntW'(pushOk) - cntW'(pop);
  assign pending_d = (pending_q && !doneFire) || pass_done_i;

  // While retiring, the entry behind the head is the one that loads next.
  assign headIdx = pop ? (rdPtr_q + ptrW'(1)) : rdPtr_q;
  assign selMask = (state_q == S_DRAIN) ? remMask_q : maskMem[headIdx];

  always_comb begin
    selCol = '0;
    for (int c = numPeX - 1; c >= 0; c--) begin
      if (selMask[c]) selCol = colW'(c);
    end
    selMaskNext = selMask;
    selMaskNext[selCol] = 1'b0;
  end

  assign rawWord = dataMem[headIdx][int'(selCol)*macResSize +: macResSize];
  assign selAddr = cfg_base_addr_i + addrMem[headIdx] * addrSize'(numPeX) + addrSize'(selCol);

`ifdef PSUM_WRITEBACK_RELU_EN
  assign outWord = rawWord[macResSize-1] ? '0 : rawWord;
`else
  assign outWord = rawWord;
`endif

  always_ff @(posedge clk) begin
    if (pushOk) begin
      dataMem[wrPtr_q] <= psum_data_i;
      addrMem[wrPtr_q] <= psum_addr_i;
      maskMem[wrPtr_q] <= psum_valid_i;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      remMask_q  <= '0;
      wrValid_q  <= 1'b0;
      wrData_q   <= '0;
      wrAddr_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      pending_q  <= 1'b0;
    end else if (!cfg_enable_i) begin
      state_q    <= S_IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      remMask_q  <= '0;
      wrValid_q  <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      pending_q <= pending_d;
      done_q    <= doneFire;
      if (pushOk) wrPtr_q <= wrPtr_q + ptrW'(1);
      if (pop) rdPtr_q <= rdPtr_q + ptrW'(1);
      if (push && !pushOk) overflow_q <= 1'b1;
      // Each load presents the lowest remaining masked column of the selected entry.
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q   <= S_DRAIN;
            wrValid_q <= 1'b1;
            wrData_q  <= outWord;
            wrAddr_q  <= selAddr;
            remMask_q <= selMaskNext;
          end
        end
        S_DRAIN: begin
          if (handshake) begin
            if (remMask_q != '0) begin
              wrData_q  <= outWord;
              wrAddr_q  <= selAddr;
              remMask_q <= selMaskNext;
            end else begin
              wrValid_q <= 1'b0;
              state_q   <= S_RETIRE;
            end
          end
        end
        S_RETIRE: begin
          if (count_q > cntW'(1)) begin
            state_q   <= S_DRAIN;
            wrValid_q <= 1'b1;
            wrData_q  <= outWord;
            wrAddr_q  <= selAddr;
            remMask_q <= selMaskNext;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_data_o       = wrData_q;
  assign wr_addr_o       = wrAddr_q;
  assign wr_valid_o      = wrValid_q;
  assign fifo_count_o    = count_q;
  assign flag_overflow_o = overflow_q;
  assign flag_done_o     = done_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Directed self-checking bench for psum_writeback; expectations follow
// PSUM_WRITEBACK_RELU_EN when it is defined.
module tb_psum_writeback;

  localparam int NPE = 3;
  localparam int W   = 20;
  localparam int AW  = 16;

  logic            clk = 1'b0;
  logic            nrst;
  logic [NPE*W-1:0] psum_data_i;
  logic [AW-1:0]   psum_addr_i;
  logic [NPE-1:0]  psum_valid_i;
  logic            cfg_enable_i;
  logic [AW-1:0]   cfg_base_addr_i;
  logic            pass_done_i;
  logic [W-1:0]    wr_data_o;
  logic [AW-1:0]   wr_addr_o;
  logic            wr_valid_o;
  logic            wr_ready_i;
  logic [2:0]      fifo_count_o;
  logic            flag_overflow_o;
  logic            flag_done_o;

  int testsRun = 0;
  int testsFailed = 0;
  int cycle = 0;

  logic [AW-1:0] gotAddr[$];
  logic [W-1:0]  gotData[$];
  int            gotCyc[$];

  psum_writeback #(.numPeX(NPE), .macResSize(W), .addrSize(AW), .fifoDepth(4)) dut (
    .clk(clk), .nrst(nrst), .psum_data_i(psum_data_i), .psum_addr_i(psum_addr_i),
    .psum_valid_i(psum_valid_i), .cfg_enable_i(cfg_enable_i), .cfg_base_addr_i(cfg_base_addr_i),
    .pass_done_i(pass_done_i), .wr_data_o(wr_data_o), .wr_addr_o(wr_addr_o),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .fifo_count_o(fifo_count_o),
    .flag_overflow_o(flag_overflow_o), .flag_done_o(flag_done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Inputs change 1 time unit after the rising edge, so the falling edge sees what the next rising edge commits.
  always @(negedge clk) begin
    if (wr_valid_o && wr_ready_i) begin
      gotAddr.push_back(wr_addr_o);
      gotData.push_back(wr_data_o);
      gotCyc.push_back(cycle);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog;
    gotAddr.delete();
    gotData.delete();
    gotCyc.delete();
  endtask

  task automatic pushRow(input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2,
                         input logic [AW-1:0] a, input logic [NPE-1:0] m);
    psum_data_i  = {d2, d1, d0};
    psum_addr_i  = a;
    psum_valid_i = m;
    tick();
    psum_valid_i = '0;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((fifo_count_o != 0 || wr_valid_o) && n < 200) begin
      tick();
      n++;
    end
    tick();
    testsRun++;
    if (n >= 200) begin
      testsFailed++;
      $display("[TB] FAIL %s drain timeout: count=%0d valid=%b", name, fifo_count_o, wr_valid_o);
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    #2;
    testsRun++;
    if ({wr_valid_o, wr_data_o, wr_addr_o, fifo_count_o, flag_overflow_o, flag_done_o} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got valid=%b data=%h addr=%h cnt=%0d ovf=%b done=%b, want all 0",
               wr_valid_o, wr_data_o, wr_addr_o, fifo_count_o, flag_overflow_o, flag_done_o);
    end
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_single_row;
    logic [AW-1:0] expA[3];
    logic [W-1:0]  expD[3];
    int n;
    bit seen;
    expA = '{16'h106, 16'h107, 16'h108};
    expD = '{20'd10, 20'hFFFFD, 20'd7};
`ifdef PSUM_WRITEBACK_RELU_EN
    expD[1] = 20'd0;
`endif
    clearLog();
    cfg_base_addr_i = 16'h100;
    wr_ready_i = 1'b1;
    pushRow(20'd10, -20'sd3, 20'd7, 16'd2, 3'b111);
    waitDrain("single_row");
    testsRun++;
    if (gotAddr.size() != 3) begin
      testsFailed++;
      $display("[TB] FAIL single_row_count: got %0d writes, want 3", gotAddr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        testsRun++;
        if (gotAddr[i] !== expA[i] || gotData[i] !== expD[i]) begin
          testsFailed++;
          $display("[TB] FAIL single_row_word%0d: got addr=%h data=%h, want addr=%h data=%h",
                   i, gotAddr[i], gotData[i], expA[i], expD[i]);
        end
      end
      testsRun++;
      if (gotCyc[1] != gotCyc[0] + 1 || gotCyc[2] != gotCyc[1] + 1) begin
        testsFailed++;
        $display("[TB] FAIL single_row_consecutive: got cycles %0d %0d %0d, want consecutive",
                 gotCyc[0], gotCyc[1], gotCyc[2]);
      end
    end
    pass_done_i = 1'b1;
    tick();
    pass_done_i = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 10) begin
      if (flag_done_o) seen = 1'b1;
      else begin tick(); n++; end
    end
    testsRun++;
    if (!seen) begin
      testsFailed++;
      $display("[TB] FAIL single_row_done: got no flag_done_o within 10 cycles, want pulse");
    end
    tick();
    testsRun++;
    if (flag_done_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_row_done_width: got flag_done_o=%b next cycle, want 0", flag_done_o);
    end
  endtask

  task automatic test_sparse_mask;
    clearLog();
    cfg_base_addr_i = 16'h0;
    wr_ready_i = 1'b1;
    pushRow(20'd100, 20'd200, 20'd300, 16'd0, 3'b101);
    waitDrain("sparse_mask");
    testsRun++;
    if (gotAddr.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL sparse_mask_count: got %0d writes, want 2", gotAddr.size());
    end else if (gotAddr[0] !== 16'h0 || gotData[0] !== 20'd100 || gotAddr[1] !== 16'h2 || gotData[1] !== 20'd300) begin
      testsFailed++;
      $display("[TB] FAIL sparse_mask_words: got %h/%0d %h/%0d, want 0000/100 0002/300",
               gotAddr[0], gotData[0], gotAddr[1], gotData[1]);
    end
  endtask

  task automatic test_backpressure;
    int n = 0;
    int bad = 0;
    clearLog();
    cfg_base_addr_i = 16'h20;
    wr_ready_i = 1'b0;
    pushRow(20'd1, 20'd2, 20'd3, 16'd1, 3'b111);
    while (!wr_valid_o && n < 10) begin tick(); n++; end
    testsRun++;
    if (wr_valid_o !== 1'b1 || wr_addr_o !== 16'h23 || wr_data_o !== 20'd1) begin
      testsFailed++;
      $display("[TB] FAIL stall_first: got valid=%b addr=%h data=%0d, want 1/0023/1", wr_valid_o, wr_addr_o, wr_data_o);
    end
    wr_ready_i = 1'b1;
    tick();
    wr_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (wr_valid_o !== 1'b1 || wr_addr_o !== 16'h24 || wr_data_o !== 20'd2) bad++;
      tick();
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++;
      $display("[TB] FAIL stall_hold: got %0d unstable cycles (addr=%h data=%0d), want 0 with 0024/2", bad, wr_addr_o, wr_data_o);
    end
    wr_ready_i = 1'b1;
    waitDrain("stall");
    testsRun++;
    if (gotAddr.size() != 3) begin
      testsFailed++;
      $display("[TB] FAIL stall_count: got %0d writes, want 3", gotAddr.size());
    end else if (gotAddr[0] !== 16'h23 || gotAddr[1] !== 16'h24 || gotAddr[2] !== 16'h25 ||
                 gotData[0] !== 20'd1 || gotData[1] !== 20'd2 || gotData[2] !== 20'd3) begin
      testsFailed++;
      $display("[TB] FAIL stall_words: got %h/%0d %h/%0d %h/%0d, want 0023/1 0024/2 0025/3",
               gotAddr[0], gotData[0], gotAddr[1], gotData[1], gotAddr[2], gotData[2]);
    end
  endtask

  task automatic test_overflow;
    int bad = 0;
    clearLog();
    cfg_base_addr_i = 16'h0;
    wr_ready_i = 1'b0;
    for (int r = 0; r < 5; r++) pushRow(20'(11 + r), 20'd0, 20'd0, 16'(r), 3'b001);
    testsRun++;
    if (fifo_count_o !== 3'd4 || flag_overflow_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL overflow_flags: got count=%0d ovf=%b, want 4/1", fifo_count_o, flag_overflow_o);
    end
    wr_ready_i = 1'b1;
    waitDrain("overflow");
    testsRun++;
    if (gotAddr.size() != 4) begin
      testsFailed++;
      $display("[TB] FAIL overflow_count: got %0d writes, want 4", gotAddr.size());
    end else begin
      for (int r = 0; r < 4; r++) begin
        if (gotAddr[r] !== 16'(3 * r) || gotData[r] !== 20'(11 + r)) bad++;
      end
      testsRun++;
      if (bad != 0) begin
        testsFailed++;
        $display("[TB] FAIL overflow_words: got %0d wrong rows (last %h/%0d), want rows 0..3 at 0,3,6,9",
                 bad, gotAddr[3], gotData[3]);
      end
    end
    testsRun++;
    if (flag_overflow_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL overflow_sticky: got %b, want 1", flag_overflow_o);
    end
    cfg_enable_i = 1'b0;
    tick();
    testsRun++;
    if (flag_overflow_o !== 1'b0 || fifo_count_o !== 3'd0 || wr_valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL disable_clear: got ovf=%b count=%0d valid=%b, want 0/0/0", flag_overflow_o, fifo_count_o, wr_valid_o);
    end
    cfg_enable_i = 1'b1;
    tick();
  endtask

  task automatic test_relu;
    logic [W-1:0] expNeg;
`ifdef PSUM_WRITEBACK_RELU_EN
    expNeg = 20'd0;
`else
    expNeg = 20'hFFFFB;
`endif
    clearLog();
    cfg_base_addr_i = 16'h40;
    wr_ready_i = 1'b1;
    pushRow(-20'sd5, 20'd9, 20'd0, 16'd0, 3'b011);
    waitDrain("relu");
    testsRun++;
    if (gotAddr.size() != 2) begin
      testsFailed++;
      $display("[TB] FAIL relu_count: got %0d writes, want 2", gotAddr.size());
    end else if (gotAddr[0] !== 16'h40 || gotData[0] !== expNeg || gotAddr[1] !== 16'h41 || gotData[1] !== 20'd9) begin
      testsFailed++;
      $display("[TB] FAIL relu_words: got %h/%h %h/%h, want 0040/%h 0041/00009",
               gotAddr[0], gotData[0], gotAddr[1], gotData[1], expNeg);
    end
  endtask

  task automatic test_done_empty;
    pass_done_i = 1'b1;
    tick();
    pass_done_i = 1'b0;
    testsRun++;
    if (flag_done_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL done_early: got %b, want 0", flag_done_o);
    end
    tick();
    testsRun++;
    if (flag_done_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL done_pulse: got %b, want 1", flag_done_o);
    end
    tick();
    testsRun++;
    if (flag_done_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL done_single: got %b, want 0", flag_done_o);
    end
  endtask

  task automatic test_reset_mid_drain;
    cfg_base_addr_i = 16'h0;
    wr_ready_i = 1'b0;
    for (int r = 0; r < 3; r++) pushRow(20'd5, 20'd6, 20'd7, 16'(r), 3'b111);
    tick();
    tick();
    clearLog();
    testsRun++;
    if (fifo_count_o !== 3'd3 || wr_valid_o !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pre_reset: got count=%0d valid=%b, want 3/1", fifo_count_o, wr_valid_o);
    end
    nrst = 1'b0;
    #1;
    testsRun++;
    if ({wr_valid_o, wr_data_o, wr_addr_o, fifo_count_o, flag_overflow_o, flag_done_o} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got valid=%b data=%h addr=%h cnt=%0d, want all 0",
               wr_valid_o, wr_data_o, wr_addr_o, fifo_count_o);
    end
    tick();
    nrst = 1'b1;
    wr_ready_i = 1'b1;
    repeat (20) tick();
    testsRun++;
    if (gotAddr.size() != 0 || fifo_count_o !== 3'd0 || wr_valid_o !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL post_reset: got %0d writes count=%0d valid=%b, want 0/0/0",
               gotAddr.size(), fifo_count_o, wr_valid_o);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nrst = 1'b0;
    psum_data_i = '0;
    psum_addr_i = '0;
    psum_valid_i = '0;
    cfg_enable_i = 1'b1;
    cfg_base_addr_i = '0;
    pass_done_i = 1'b0;
    wr_ready_i = 1'b0;
    test_reset();
    test_single_row();
    test_sparse_mask();
    test_backpressure();
    test_overflow();
    test_relu();
    test_done_empty();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
